// File: rtl/minibus_mem_arbiter.sv
// rtl/minibus_mem_arbiter.sv - multi-channel minibus memory arbiter with FREE/BUS_OP/READY FSM
// Optional bus timeout when MINIBUS_TIMEOUT_EN is defined.
module minibus_mem_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RR_EN       = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_ren,
  input  logic [NUM_CH-1:0]        ch_wen,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH*2-1:0]      ch_width,
  output logic [NUM_CH-1:0]        ch_hit,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  output logic [1:0]               bus_width,
  output logic                     bus_wen,
  output logic                     bus_ren,
  input  logic                     bus_ack,
  input  logic [DATA_W-1:0]        bus_rdata
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_chk
    $error("minibus_mem_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {FREE, BUS_OP, READY} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d, rr_q, rr_d, win, sel;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]          width_q, width_d;
  logic                wr_q, wr_d, any_pend, held;
  logic [NUM_CH-1:0]   pend;
  int                  idx;
`ifdef MINIBUS_TIMEOUT_EN
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  assign pend = ch_ren | ch_wen;

  // Search starts at rr_q for round-robin, at 0 for fixed priority.
  always_comb begin
    win      = '0;
    sel      = '0;
    idx      = 0;
    any_pend = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (RR_EN != 0) ? ((int'(rr_q) + k) % NUM_CH) : k;
      sel = IDX_W'(idx);
      if (!any_pend && pend[sel]) begin
        any_pend = 1'b1;
        win      = sel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
`ifdef MINIBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      FREE: begin
        if (any_pend) begin
          grant_d = win;
          rr_d    = IDX_W'((int'(win) + 1) % NUM_CH);
          addr_d  = ch_addr[win*ADDR_W +: ADDR_W];
          wdata_d = ch_wdata[win*DATA_W +: DATA_W];
          width_d = ch_width[win*2 +: 2];
          wr_d    = ch_wen[win];
          state_d = BUS_OP;
`ifdef MINIBUS_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      BUS_OP: begin
        if (bus_ack) begin
          rdata_d = wr_q ? '0 : bus_rdata;
          addr_d  = '0;
          wdata_d = '0;
          width_d = '0;
          state_d = READY;
        end
`ifdef MINIBUS_TIMEOUT_EN
        else if ({1'b0, cnt_q} + 17'd1 >= 17'(TIMEOUT_CYC)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          addr_d  = '0;
          wdata_d = '0;
          width_d = '0;
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        rdata_d = '0;
        state_d = FREE;
`ifdef MINIBUS_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FREE;
      grant_q <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
`ifdef MINIBUS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
`ifdef MINIBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus_ren   = (state_q == BUS_OP) && !wr_q;
  assign bus_wen   = (state_q == BUS_OP) && wr_q;
  assign bus_addr  = (state_q == BUS_OP) ? addr_q  : '0;
  assign bus_wdata = (state_q == BUS_OP) ? wdata_q : '0;
  assign bus_width = (state_q == BUS_OP) ? width_q : '0;

  // A channel that withdrew its request before READY gets no hit.
  assign held = wr_q ? ch_wen[grant_q] : ch_ren[grant_q];

  always_comb begin
    ch_hit   = '0;
    ch_err   = '0;
    ch_rdata = '0;
    if (state_q == READY) begin
`ifdef MINIBUS_TIMEOUT_EN
      if (err_q) begin
        ch_hit[grant_q] = 1'b1;
        ch_err[grant_q] = 1'b1;
      end else
`endif
      if (held) begin
        ch_hit[grant_q] = 1'b1;
        if (!wr_q) ch_rdata = rdata_q;
      end
    end
  end
endmodule

// File: tb/tb_minibus_mem_arbiter.sv
// tb/tb_minibus_mem_arbiter.sv - self-checking bench for minibus_mem_arbiter
module tb_minibus_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance a: 2 channels, fixed priority, short timeout.
  logic [1:0]  a_ren, a_wen, a_hit, a_err;
  logic [63:0] a_addr, a_wdata;
  logic [3:0]  a_width;
  logic [31:0] a_rdata, a_baddr, a_bwdata, a_brdata;
  logic [1:0]  a_bwidth;
  logic        a_bwen, a_bren, a_ack;

  // Instance b: 4 channels, round-robin.
  logic [3:0]   b_ren, b_wen, b_hit, b_err;
  logic [127:0] b_addr, b_wdata;
  logic [7:0]   b_width;
  logic [31:0]  b_rdata, b_baddr, b_bwdata, b_brdata;
  logic [1:0]   b_bwidth;
  logic         b_bwen, b_bren, b_ack;

  minibus_mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT_CYC(4)) dut_a (
    .clk(clk), .rst(rst), .ch_ren(a_ren), .ch_wen(a_wen), .ch_addr(a_addr), .ch_wdata(a_wdata),
    .ch_width(a_width), .ch_hit(a_hit), .ch_err(a_err), .ch_rdata(a_rdata), .bus_addr(a_baddr),
    .bus_wdata(a_bwdata), .bus_width(a_bwidth), .bus_wen(a_bwen), .bus_ren(a_bren),
    .bus_ack(a_ack), .bus_rdata(a_brdata));

  minibus_mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT_CYC(255)) dut_b (
    .clk(clk), .rst(rst), .ch_ren(b_ren), .ch_wen(b_wen), .ch_addr(b_addr), .ch_wdata(b_wdata),
    .ch_width(b_width), .ch_hit(b_hit), .ch_err(b_err), .ch_rdata(b_rdata), .bus_addr(b_baddr),
    .bus_wdata(b_bwdata), .bus_width(b_bwidth), .bus_wen(b_bwen), .bus_ren(b_bren),
    .bus_ack(b_ack), .bus_rdata(b_brdata));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    a_ren = '0; a_wen = '0; a_addr = '0; a_wdata = '0; a_width = '0; a_ack = 1'b0; a_brdata = '0;
    b_ren = '0; b_wen = '0; b_addr = '0; b_wdata = '0; b_width = '0; b_ack = 1'b0; b_brdata = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  ren, wen;
    logic [31:0] addr, wdata;
    logic [1:0]  width;
    logic        ack;
    logic [31:0] brdata;
    logic [1:0]  e_hit;
    logic [31:0] e_rdata;
    logic        e_bren, e_bwen;
    logic [31:0] e_baddr;
    logic [1:0]  e_bwidth;
    logic [31:0] e_bwdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] ren, input logic [1:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] width, input logic ack,
                     input logic [31:0] brdata, input logic [1:0] e_hit, input logic [31:0] e_rdata,
                     input logic e_bren, input logic e_bwen, input logic [31:0] e_baddr,
                     input logic [1:0] e_bwidth, input logic [31:0] e_bwdata);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata; v.width = width; v.ack = ack;
    v.brdata = brdata; v.e_hit = e_hit; v.e_rdata = e_rdata; v.e_bren = e_bren; v.e_bwen = e_bwen;
    v.e_baddr = e_baddr; v.e_bwidth = e_bwidth; v.e_bwdata = e_bwdata;
    vecs.push_back(v);
  endtask

  // Behavioural reference for instance b: one outstanding transaction described by its phase.
  int          m_phase, m_g, m_ptr, pick;
  logic        m_wr, held;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_width;
  logic [3:0]  hit_prev, e_hit, pend;
  logic [31:0] e_rdata;

  task automatic new_req(input int i);
    int op;
    op = $urandom_range(0, 2);
    b_ren[i] = (op != 1);
    b_wen[i] = (op != 0);
    b_addr[i*32 +: 32]  = $urandom;
    b_wdata[i*32 +: 32] = $urandom;
    b_width[i*2 +: 2]   = 2'($urandom_range(0, 2));
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    a_ren = 2'b11; a_ack = 1'b1; b_ren = 4'hF; b_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outputs_a", {a_hit, a_err, a_rdata, a_bren, a_bwen, a_baddr, a_bwdata, a_bwidth}, '0);
    chk("reset_outputs_b", {b_hit, b_err, b_rdata, b_bren, b_bwen, b_baddr, b_bwdata, b_bwidth}, '0);

    // Directed vectors on instance a, one row per cycle starting right after reset.
    add(2'b10, 2'b00, 32'h100, 32'h0, 2'b10, 1'b0, 32'h0,        2'b00, 32'h0,        0, 0, 32'h0,   2'b00, 32'h0);
    add(2'b10, 2'b00, 32'h100, 32'h0, 2'b10, 1'b1, 32'hDEADBEEF, 2'b00, 32'h0,        1, 0, 32'h100, 2'b10, 32'h0);
    add(2'b10, 2'b00, 32'h100, 32'h0, 2'b10, 1'b0, 32'h0,        2'b10, 32'hDEADBEEF, 0, 0, 32'h0,   2'b00, 32'h0);
    add(2'b00, 2'b00, 32'h0,   32'h0, 2'b00, 1'b1, 32'h5555,     2'b00, 32'h0,        0, 0, 32'h0,   2'b00, 32'h0);
    add(2'b00, 2'b01, 32'h40, 32'h12345678, 2'b00, 1'b1, 32'h9999, 2'b00, 32'h0, 0, 0, 32'h0,  2'b00, 32'h0);
    add(2'b00, 2'b01, 32'h40, 32'h12345678, 2'b00, 1'b0, 32'h0,    2'b00, 32'h0, 0, 1, 32'h40, 2'b00, 32'h12345678);
    add(2'b00, 2'b01, 32'h40, 32'h12345678, 2'b00, 1'b0, 32'h0,    2'b00, 32'h0, 0, 1, 32'h40, 2'b00, 32'h12345678);
    add(2'b00, 2'b01, 32'h40, 32'h12345678, 2'b00, 1'b1, 32'h7777, 2'b00, 32'h0, 0, 1, 32'h40, 2'b00, 32'h12345678);
    add(2'b00, 2'b01, 32'h40, 32'h12345678, 2'b00, 1'b0, 32'h0,    2'b01, 32'h0, 0, 0, 32'h0,  2'b00, 32'h0);
    add(2'b00, 2'b00, 32'h0,  32'h0,        2'b00, 1'b0, 32'h0,    2'b00, 32'h0, 0, 0, 32'h0,  2'b00, 32'h0);
    add(2'b01, 2'b01, 32'h8,  32'hAA,       2'b01, 1'b0, 32'h0,    2'b00, 32'h0, 0, 0, 32'h0,  2'b00, 32'h0);
    add(2'b01, 2'b01, 32'h8,  32'hAA,       2'b01, 1'b1, 32'h1234, 2'b00, 32'h0, 0, 1, 32'h8,  2'b01, 32'hAA);
    add(2'b01, 2'b01, 32'h8,  32'hAA,       2'b01, 1'b0, 32'h0,    2'b01, 32'h0, 0, 0, 32'h0,  2'b00, 32'h0);
    add(2'b00, 2'b00, 32'h0,  32'h0,        2'b00, 1'b0, 32'h0,    2'b00, 32'h0, 0, 0, 32'h0,  2'b00, 32'h0);

    do_reset();
    for (int r = 0; r < vecs.size(); r++) begin
      a_ren = vecs[r].ren; a_wen = vecs[r].wen;
      a_addr = {2{vecs[r].addr}}; a_wdata = {2{vecs[r].wdata}}; a_width = {2{vecs[r].width}};
      a_ack = vecs[r].ack; a_brdata = vecs[r].brdata;
      @(negedge clk);
      chk($sformatf("vec%0d_hit", r), {a_hit, a_err, a_rdata}, {vecs[r].e_hit, 2'b00, vecs[r].e_rdata});
      chk($sformatf("vec%0d_bus", r), {a_bren, a_bwen, a_baddr, a_bwidth, a_bwdata},
          {vecs[r].e_bren, vecs[r].e_bwen, vecs[r].e_baddr, vecs[r].e_bwidth, vecs[r].e_bwdata});
      next_cycle();
    end

    // Fixed priority with both channels reading and immediate acks: ch1 starves.
    do_reset();
    a_ren = 2'b11; a_ack = 1'b1; a_brdata = 32'hCAFE0001;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("fixed_hit_c%0d", c), {a_hit, a_rdata}, (c % 3 == 2) ? {2'b01, 32'hCAFE0001} : '0);
      next_cycle();
    end

    // Reset asserted during BUS_OP drops the bus at once; held request restarts.
    do_reset();
    a_ren = 2'b01; a_addr = {32'h0, 32'h77}; a_width = 4'b0010;
    @(negedge clk);
    chk("midrst_c0", {a_bren, a_baddr}, '0);
    next_cycle();
    @(negedge clk);
    chk("midrst_c1", {a_bren, a_baddr}, {1'b1, 32'h77});
    #1 rst = 1'b1;
    #1 chk("midrst_async", {a_bren, a_bwen, a_baddr, a_bwidth, a_hit}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_after_c0", {a_bren, a_baddr}, '0);
    next_cycle();
    @(negedge clk);
    chk("midrst_after_c1", {a_bren, a_baddr, a_bwidth}, {1'b1, 32'h77, 2'b10});

    // No ack at all: timeout error after TIMEOUT_CYC bus cycles, or indefinite wait.
    do_reset();
    a_ren = 2'b01; a_addr = {32'h0, 32'h55}; a_brdata = 32'hFFFF;
`ifdef MINIBUS_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 4) chk("tmo_c4_busy", {a_bren, a_hit}, {1'b1, 2'b00});
      if (c == 5) chk("tmo_c5_err", {a_hit, a_err, a_rdata, a_bren}, {2'b01, 2'b01, 32'h0, 1'b0});
      if (c == 6) chk("tmo_c6_free", {a_hit, a_err, a_bren}, '0);
      next_cycle();
    end
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 1) chk($sformatf("noack_wait_c%0d", c), {a_bren, a_hit, a_err}, {1'b1, 2'b00, 2'b00});
      next_cycle();
    end
`endif

    // Round-robin, all four channels reading, immediate acks.
    do_reset();
    b_ren = 4'hF; b_ack = 1'b1; b_addr = {32'h40, 32'h30, 32'h20, 32'h10};
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk($sformatf("rr_hit_c%0d", c), b_hit, (c % 3 == 2) ? (128'd1 << ((c / 3) % 4)) : '0);
      if (c % 3 == 1) chk($sformatf("rr_addr_c%0d", c), b_baddr, 32'h10 * ((c / 3) % 4 + 1));
      next_cycle();
    end

    // Withdraw during BUS_OP: no hit, pointer still moves past ch0.
    do_reset();
    b_ren = 4'b0001; b_addr = {32'h40, 32'h30, 32'h20, 32'h10};
    next_cycle();
    @(negedge clk);
    chk("wd_c1_bus", {b_bren, b_baddr}, {1'b1, 32'h10});
    next_cycle();
    b_ren = 4'b0000; b_ack = 1'b1;
    next_cycle();
    b_ack = 1'b0;
    @(negedge clk);
    chk("wd_c3_nohit", {b_hit, b_rdata, b_bren}, '0);
    next_cycle();
    b_ren = 4'b0011;
    next_cycle();
    @(negedge clk);
    chk("wd_c5_grant1", {b_bren, b_baddr}, {1'b1, 32'h20});

    // Randomized run against the transaction-level model.
    do_reset();
    m_phase = 0; m_ptr = 0; m_g = 0; m_wr = 1'b0; hit_prev = '0;
    m_addr = '0; m_wdata = '0; m_width = '0; m_rdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        pend = b_ren | b_wen;
        if (m_phase == 0) begin
          if (pend != 0) begin
            pick = -1;
            for (int k = 0; k < 4; k++)
              if (pick < 0 && pend[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
            m_g = pick;
            m_ptr = (pick + 1) % 4;
            m_wr = b_wen[pick];
            m_addr = b_addr[pick*32 +: 32];
            m_wdata = b_wdata[pick*32 +: 32];
            m_width = b_width[pick*2 +: 2];
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          if (b_ack) begin
            m_rdata = m_wr ? 32'h0 : b_brdata;
            m_phase = 2;
          end
        end else begin
          m_phase = 0;
        end
        #1;
      end
      for (int i = 0; i < 4; i++) begin
        if (hit_prev[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else begin b_ren[i] = 1'b0; b_wen[i] = 1'b0; end
        end else if (!(b_ren[i] || b_wen[i])) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if (m_phase != 0 && m_g == i && $urandom_range(0, 19) == 0) begin
          b_ren[i] = 1'b0; b_wen[i] = 1'b0;
        end
      end
      b_ack = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      b_brdata = $urandom;
      @(negedge clk);
      held = m_wr ? b_wen[m_g] : b_ren[m_g];
      e_hit = (m_phase == 2 && held) ? (4'b0001 << m_g) : 4'b0000;
      e_rdata = (e_hit != 0 && !m_wr) ? m_rdata : 32'h0;
      chk($sformatf("rand_bus_c%0d", cyc), {b_bren, b_bwen, b_baddr, b_bwidth, b_bwdata},
          (m_phase == 1) ? {!m_wr, m_wr, m_addr, m_width, m_wdata} : '0);
      chk($sformatf("rand_hit_c%0d", cyc), {b_hit, b_err, b_rdata}, {e_hit, 4'b0000, e_rdata});
      hit_prev = e_hit;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
